// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, instruction field layout and datapath defaults
package alu_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_LIT_W  = 15;
    localparam int REG_AW         = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd31;

    localparam int FN_HI   = 31;
    localparam int FN_LO   = 26;
    localparam int LIT_BIT = 25;
    localparam int RC_HI   = 24;
    localparam int RC_LO   = 20;
    localparam int RA_HI   = 19;
    localparam int RA_LO   = 15;
    localparam int RB_HI   = 14;
    localparam int RB_LO   = 10;

    localparam logic [5:0] ALUFN_ADD  = 6'b010000;
    localparam logic [5:0] ALUFN_SUB  = 6'b010001;
    localparam logic [5:0] ALUFN_AND  = 6'b101000;
    localparam logic [5:0] ALUFN_OR   = 6'b101110;
    localparam logic [5:0] ALUFN_XOR  = 6'b100110;
    localparam logic [5:0] ALUFN_XNOR = 6'b101001;
    localparam logic [5:0] ALUFN_A    = 6'b101010;

    function automatic logic is_legal_alufn(input logic [5:0] fn);
        case (fn)
            ALUFN_ADD, ALUFN_SUB, ALUFN_AND, ALUFN_OR,
            ALUFN_XOR, ALUFN_XNOR, ALUFN_A: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 2-read/1-write register file, top register hardwired to zero
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wr_addr != REG_ZERO) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-edge contents; a same-cycle write is not passed through.
    assign ra_data = (ra_addr == REG_ZERO) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == REG_ZERO) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - decode/operand fetch ahead of the ALU; ALU_OPERAND_FWD_EN adds W-stage bypass
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LIT_W  = DEFAULT_LIT_W,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic [5:0]        alu_fn,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_illegal,
    output logic              busy
);

    logic [5:0]        d_fn;
    logic              d_lit;
    logic              d_legal;
    logic [REG_AW-1:0] d_rc;
    logic [REG_AW-1:0] d_ra;
    logic [REG_AW-1:0] d_rb;
    logic [LIT_W-1:0]  d_imm;
    logic [DATA_W-1:0] d_imm_ext;

    assign d_fn      = in_instr[FN_HI:FN_LO];
    assign d_lit     = in_instr[LIT_BIT];
    assign d_rc      = in_instr[RC_HI:RC_LO];
    assign d_ra      = in_instr[RA_HI:RA_LO];
    assign d_rb      = in_instr[RB_HI:RB_LO];
    assign d_imm     = in_instr[LIT_W-1:0];
    assign d_imm_ext = {{(DATA_W-LIT_W){d_imm[LIT_W-1]}}, d_imm};
    assign d_legal   = is_legal_alufn(d_fn);

    logic              e_valid;
    logic [REG_AW-1:0] e_rc;
    logic              w_valid;
    logic [REG_AW-1:0] w_rc;

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (d_ra),
        .ra_data (rf_a),
        .rb_addr (d_rb),
        .rb_data (rf_b),
        .we      (w_valid),
        .wr_addr (w_rc),
        .wr_data (alu_y)
    );

    // Only legal in-flight writers to a real register can conflict.
    logic e_writes;
    logic w_writes;
    logic a_hit_e;
    logic b_hit_e;
    logic a_hit_w;
    logic b_hit_w;

    assign e_writes = e_valid && (e_rc != REG_ZERO);
    assign w_writes = w_valid && (w_rc != REG_ZERO);
    assign a_hit_e  = e_writes && (d_ra == e_rc);
    assign b_hit_e  = e_writes && !d_lit && (d_rb == e_rc);
    assign a_hit_w  = w_writes && (d_ra == w_rc);
    assign b_hit_w  = w_writes && !d_lit && (d_rb == w_rc);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b_reg;
    logic [DATA_W-1:0] op_b;

`ifdef ALU_OPERAND_FWD_EN
    assign in_ready = !(a_hit_e || b_hit_e);
    assign op_a     = a_hit_w ? alu_y : rf_a;
    assign op_b_reg = b_hit_w ? alu_y : rf_b;
`else
    assign in_ready = !(a_hit_e || b_hit_e || a_hit_w || b_hit_w);
    assign op_a     = rf_a;
    assign op_b_reg = rf_b;
`endif

    assign op_b = d_lit ? d_imm_ext : op_b_reg;

    logic accept;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid     <= 1'b0;
            e_rc        <= '0;
            w_valid     <= 1'b0;
            w_rc        <= '0;
            err_illegal <= 1'b0;
            alu_fn      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
        end else begin
            // Illegal codes are consumed but travel as bubbles.
            e_valid     <= accept && d_legal;
            e_rc        <= d_rc;
            err_illegal <= accept && !d_legal;
            w_valid     <= e_valid;
            w_rc        <= e_rc;
            if (accept) begin
                alu_fn <= d_fn;
                alu_a  <= op_a;
                alu_b  <= op_b;
            end
        end
    end

    assign wb_valid = w_valid;
    assign wb_addr  = w_rc;
    assign wb_data  = alu_y;
    assign busy     = e_valid || w_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed and randomized checks of alu_operand_stage against an in-order architectural model
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [5:0]  alu_fn;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_illegal;
    logic        busy;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .alu_fn      (alu_fn),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_y       (alu_y),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err_illegal (err_illegal),
        .busy        (busy)
    );

`ifdef ALU_OPERAND_FWD_EN
    localparam int DEP_STALLS = 1;
`else
    localparam int DEP_STALLS = 2;
`endif

    localparam logic [5:0] F_ADD  = 6'b010000;
    localparam logic [5:0] F_SUB  = 6'b010001;
    localparam logic [5:0] F_AND  = 6'b101000;
    localparam logic [5:0] F_OR   = 6'b101110;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_XNOR = 6'b101001;
    localparam logic [5:0] F_A    = 6'b101010;

    logic [5:0] fns [7] = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_XNOR, F_A};

    function automatic logic is_legal(input logic [5:0] fn);
        return (fn == F_ADD) || (fn == F_SUB) || (fn == F_AND) || (fn == F_OR) ||
               (fn == F_XOR) || (fn == F_XNOR) || (fn == F_A);
    endfunction

    function automatic logic [31:0] alu_f(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        if (fn == F_ADD)  return a + b;
        if (fn == F_SUB)  return a - b;
        if (fn == F_AND)  return a & b;
        if (fn == F_OR)   return a | b;
        if (fn == F_XOR)  return a ^ b;
        if (fn == F_XNOR) return ~(a ^ b);
        if (fn == F_A)    return a;
        return 32'h0;
    endfunction

    // Registered ALU sitting downstream of the stage
    always @(posedge clk) alu_y <= alu_f(alu_fn, alu_a, alu_b);

    function automatic logic [31:0] mk(input logic [5:0] fn, input logic lit, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [14:0] tail);
        return {fn, lit, rc, ra, tail};
    endfunction

    function automatic logic [14:0] rr(input logic [4:0] rb);
        return {rb, 10'd0};
    endfunction

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [4:0]  rc;
        logic [31:0] data;
    } slot_t;

    logic [31:0] ref_regs [32];
    slot_t       pe;
    slot_t       pw;
    logic [5:0]  exp_fn;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        last_acc;
    int          wb_seen;
    int          total;
    int          bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: decide acceptance from settled inputs, advance the model, compare after the edge.
    task automatic tick();
        logic        acc;
        slot_t       ne;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        #1;
        acc = ((in_valid && in_ready && !rst) === 1'b1);
        ne  = '0;
        fn  = in_instr[31:26];
        a   = 32'h0;
        b   = 32'h0;
        if (acc) begin
            a = ref_regs[in_instr[19:15]];
            b = in_instr[25] ? {{17{in_instr[14]}}, in_instr[14:0]} : ref_regs[in_instr[14:10]];
            ne.valid   = is_legal(fn);
            ne.illegal = !is_legal(fn);
            ne.rc      = in_instr[24:20];
            ne.data    = alu_f(fn, a, b);
            if (ne.valid && ne.rc != 5'd31) ref_regs[ne.rc] = ne.data;
        end
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            pe = '0;
            pw = '0;
            exp_fn = '0;
            exp_a = '0;
            exp_b = '0;
            for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        end else begin
            pw = pe;
            pe = ne;
            if (acc) begin
                exp_fn = fn;
                exp_a  = a;
                exp_b  = b;
            end
        end
        last_acc = acc;
        check("alu_fn", {26'd0, alu_fn}, {26'd0, exp_fn});
        check("alu_a", alu_a, exp_a);
        check("alu_b", alu_b, exp_b);
        check("err_illegal", {31'd0, err_illegal}, {31'd0, pe.illegal});
        check("busy", {31'd0, busy}, {31'd0, pe.valid || pw.valid});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, pw.valid});
        if (pw.valid) begin
            wb_seen++;
            check("wb_addr", {27'd0, wb_addr}, {27'd0, pw.rc});
            check("wb_data", wb_data, pw.data);
        end
    endtask

    task automatic issue(input logic [31:0] instr, output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_instr = instr;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (last_acc) break;
            stalls++;
        end
        check("issue_accepted", {31'd0, last_acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int          s;
        int          tot;
        int          wb0;
        logic [5:0]  fn;
        logic [4:0]  rc;
        logic [4:0]  ra;
        logic [4:0]  rb;
        total    = 0;
        bad      = 0;
        wb_seen  = 0;
        last_acc = 1'b0;
        pe = '0;
        pw = '0;
        exp_fn = '0;
        exp_a = '0;
        exp_b = '0;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        idle(1);
        #1 check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // R1 = 0 + 5, then R2 = R1 - (-1) depends on R1
        issue(mk(F_ADD, 1'b1, 5'd1, 5'd31, 15'd5), s);
        check("add_lit_stalls", s, 0);
        issue(mk(F_SUB, 1'b1, 5'd2, 5'd1, 15'h7FFF), s);
        check("sub_dep_stalls", s, DEP_STALLS);
        check("sub_lit_b", alu_b, 32'hFFFF_FFFF);
        idle(3);

        // R3 = R1 + R1 then R4 = R3 ^ R1
        issue(mk(F_ADD, 1'b0, 5'd3, 5'd1, rr(5'd1)), s);
        issue(mk(F_XOR, 1'b0, 5'd4, 5'd3, rr(5'd1)), s);
        check("dep_stalls", s, DEP_STALLS);
        idle(3);

        // Independent stream on R5..R12
        wb0 = wb_seen;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            issue(mk(fns[i % 7], 1'b0, 5'(5 + i), (i % 2 == 1) ? 5'd1 : 5'd2, rr(5'd2)), s);
            tot += s;
        end
        check("stream_stalls", tot, 0);
        idle(3);
        check("stream_wb_count", wb_seen - wb0, 8);

        // Illegal op to R13, dependent follower must not stall
        issue(mk(6'b000000, 1'b0, 5'd13, 5'd1, rr(5'd2)), s);
        issue(mk(F_ADD, 1'b0, 5'd14, 5'd13, rr(5'd13)), s);
        check("after_illegal_stalls", s, 0);
        idle(3);

        // Writes to R31 are dropped and reading it never stalls
        issue(mk(F_SUB, 1'b1, 5'd31, 5'd31, 15'h1111), s);
        issue(mk(F_A, 1'b0, 5'd15, 5'd31, rr(5'd31)), s);
        check("r31_stalls", s, 0);
        check("r31_reads_zero", alu_a, 32'd0);
        idle(3);

        // Reset with an op in flight
        issue(mk(F_ADD, 1'b1, 5'd16, 5'd31, 15'd99), s);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        for (int r = 0; r < 32; r++) begin
            issue(mk(F_A, 1'b0, 5'd31, 5'(r), rr(5'd0)), s);
            check("reg_cleared", alu_a, 32'd0);
        end
        idle(2);

        // Randomized traffic with a small register pool to provoke hazards
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            rc = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(1, 6));
            ra = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(1, 6));
            rb = 5'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1)
                issue(mk(fn, 1'b1, rc, ra, 15'($urandom)), s);
            else
                issue(mk(fn, 1'b0, rc, ra, rr(rb)), s);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
